seq_divider: RTL

Parametrised multi-cycle divider that succeeds the single-cycle divide path behind ALU op 01111 in the Phase 1 datapath. It computes quotient and remainder with a restoring shift-subtract algorithm over WIDTH iterations. It supports signed and unsigned operation, selected per operation, and flags divide-by-zero. Its outputs feed the Z register pair: quotient goes to Zlow (then LO), remainder goes to Zhigh (then HI). A start/done handshake lets the control unit stall across the operation.

---
 rtl/seq_divider.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: signed/unsigned quotient and remainder over WIDTH
// shift-subtract iterations, with a start/done handshake and divide-by-zero flag.
module seq_divider #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       fsm_state
);

  // Handshake: start is sampled only in IDLE; done pulses for one cycle with results
  // valid from that cycle; busy covers every cycle between acceptance and done.
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIXUP = 2'd2} state_t;

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_mag;
  logic             sign_q, sign_r, dz_pend;
  logic             use_signed;
  logic [WIDTH:0]   top, trial;

  assign use_signed = SIGNED_EN && signed_mode;
  assign busy       = (state != IDLE);
  assign fsm_state  = state;

  always_comb begin
    top   = {rem_reg, dvd_reg[WIDTH-1]};
    trial = top - {1'b0, dvs_mag};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? FIXUP : ITER;
      ITER:    if (cnt == LAST) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt         <= '0;
      rem_reg     <= '0;
      dvd_reg     <= '0;
      dvs_mag     <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz_pend     <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            rem_reg <= '0;
            if (divisor == '0) begin
              // Raw dividend is kept in the dividend register for the remainder output.
              dvd_reg <= dividend;
              dvs_mag <= '0;
              sign_q  <= 1'b0;
              sign_r  <= 1'b0;
              dz_pend <= 1'b1;
            end else begin
              dvd_reg <= (use_signed && dividend[WIDTH-1]) ? -dividend : dividend;
              dvs_mag <= (use_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
              sign_q  <= use_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              sign_r  <= use_signed && dividend[WIDTH-1];
              dz_pend <= 1'b0;
            end
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (!trial[WIDTH]) begin
            rem_reg <= trial[WIDTH-1:0];
            dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= top[WIDTH-1:0];
            dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
          end
        end
        FIXUP: begin
          done        <= 1'b1;
          div_by_zero <= dz_pend;
          if (dz_pend) begin
            quotient  <= '1;
            remainder <= dvd_reg;
          end else begin
            quotient  <= sign_q ? -dvd_reg : dvd_reg;
            remainder <= sign_r ? -rem_reg : rem_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
